// File: rtl/dma_to_finn_fifo_pkg.sv
// Shared types and helpers for the DMA-to-FINN ingress buffer.
package dma_to_finn_pkg;

  typedef enum logic {COUNT, OVERRUN} chk_state_t;

  // Pointer carries one extra wrap bit above the index bits.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/dma_to_finn_fifo_if.sv
// AXI-Stream style beat bundle used on both sides of the ingress buffer.
interface dma_to_finn_fifo_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  tvalid;
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tlast;
  logic                  tready;

  modport master (output tvalid, output tdata, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/dma_to_finn_fifo_fifo_mem.sv
// Power-of-two FIFO with wrap-bit pointers and an asynchronous read port.
module stream_fifo_mem
  import dma_to_finn_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_valid,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ready,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  rd_ready
);
  localparam int PW = ptr_w(DEPTH);
  localparam int IW = PW - 1;

  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  full, empty, wr_en, rd_en;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[IW-1:0] == rd_ptr[IW-1:0]) && (wr_ptr[IW] != rd_ptr[IW]);
  assign wr_ready = ~full;
  assign rd_valid = ~empty;
  assign wr_en    = wr_valid & wr_ready;
  assign rd_en    = rd_valid & rd_ready;
  assign rd_data  = mem[rd_ptr[IW-1:0]];

  // Storage is intentionally not reset; validity comes from the pointers.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[IW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (rd_en) rd_ptr <= rd_ptr + PW'(1);
    end
  end

endmodule

// File: rtl/dma_to_finn_fifo.sv
// DMA MM2S to FINN ingress: buffers beats, strips TLAST, and checks frame lengths.
module dma_to_finn_fifo
  import dma_to_finn_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int DATA_WIDTH  = 8,
  parameter int FRAME_BEATS = 16,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  dma_to_finn_fifo_if.slave    s_axis,
  dma_to_finn_fifo_if.master   m_axis,
  input  logic                 err_clear,
  output logic                 frame_done,
  output logic                 err_short,
  output logic                 err_long,
  output logic [CNT_WIDTH-1:0] frames_ok
);
  localparam int CW = (FRAME_BEATS > 1) ? $clog2(FRAME_BEATS) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(FRAME_BEATS - 1);

  chk_state_t     state;
  logic [CW-1:0]  beat_cnt;
  logic           s_hs;

  stream_fifo_mem #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_mem (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_valid (s_axis.tvalid),
    .wr_data  (s_axis.tdata),
    .wr_ready (s_axis.tready),
    .rd_valid (m_axis.tvalid),
    .rd_data  (m_axis.tdata),
    .rd_ready (m_axis.tready)
  );

  // FINN has no end-of-packet input; the downstream tlast is tied off.
  assign m_axis.tlast = 1'b0;
  assign s_hs = s_axis.tvalid & s_axis.tready;

  // Clear is applied first so a same-cycle set event overrides it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= COUNT;
      beat_cnt   <= '0;
      frames_ok  <= '0;
      frame_done <= 1'b0;
      err_short  <= 1'b0;
      err_long   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (err_clear) begin
        err_short <= 1'b0;
        err_long  <= 1'b0;
      end
      if (s_hs) begin
        case (state)
          COUNT: begin
            if (s_axis.tlast && beat_cnt == LAST_BEAT) begin
              frame_done <= 1'b1;
              frames_ok  <= frames_ok + CNT_WIDTH'(1);
              beat_cnt   <= '0;
            end else if (s_axis.tlast) begin
              err_short <= 1'b1;
              beat_cnt  <= '0;
            end else if (beat_cnt == LAST_BEAT) begin
              err_long <= 1'b1;
              beat_cnt <= '0;
              state    <= OVERRUN;
            end else begin
              beat_cnt <= beat_cnt + CW'(1);
            end
          end
          OVERRUN: begin
            if (s_axis.tlast) begin
              beat_cnt <= '0;
              state    <= COUNT;
            end
          end
          default: state <= COUNT;
        endcase
      end
    end
  end

endmodule
